// File: rtl/spi_master_ctrl_if.sv
// Requester-side bundle of spi_master_ctrl: transaction request in, status and read data out.
interface spi_master_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              start;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              busy;
    logic              done;
    logic              err;

    modport master (output start, wr, addr, din, input dout, busy, done, err);
    modport slave  (input start, wr, addr, din, output dout, busy, done, err);
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one {data, addr, wr} frame out LSB-first, optional data word back,
// with address range check and handshake timeout.
module spi_master_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 32,
    parameter int CLK_DIV   = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_ctrl_if.slave bus,
    output logic             cs_n,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    input  logic             ready,
    input  logic             op_done
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int N_RD    = 1 + ADDR_W;
    localparam int CNT_MAX = (FRAME_W > TIMEOUT) ? FRAME_W : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PH_W    = $clog2(2 * CLK_DIV);

    localparam logic [PH_W-1:0]  PH_RISE = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(N_RD - 1);
    localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [31:0]      DEPTH_U = 32'(MEM_DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_SEND     = 3'd2;
    localparam logic [2:0] S_WAIT_OP  = 3'd3;
    localparam logic [2:0] S_WAIT_RDY = 3'd4;
    localparam logic [2:0] S_RECV     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;
    localparam logic [2:0] S_ERROR    = 3'd7;

    logic [2:0]         state_r;
    logic [FRAME_W-1:0] frame_r;
    logic               wr_r;
    logic [PH_W-1:0]    ph_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [DATA_W-1:0]  rx_r;
    logic [DATA_W-1:0]  dout_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic               cs_n_r;
    logic               sclk_r;
    logic               mosi_r;

    logic [CNT_W-1:0]   cnt_inc_s;
    logic               send_last_s;
    logic               hs_s;
    logic               addr_ok_s;

    assign cnt_inc_s   = cnt_r + CNT_W'(1);
    assign send_last_s = (cnt_r == (wr_r ? LAST_WR : LAST_RD));
    assign hs_s        = (state_r == S_WAIT_OP) ? op_done : ready;
    // The address field sits just above the wr bit until SEND starts shifting.
    assign addr_ok_s   = (32'(frame_r[ADDR_W:1]) < DEPTH_U);

    assign bus.dout = dout_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;
    assign cs_n     = cs_n_r;
    assign sclk     = sclk_r;
    assign mosi     = mosi_r;

    // Transaction sequencer, serial timing generator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            frame_r <= '0;
            wr_r    <= 1'b0;
            ph_r    <= '0;
            cnt_r   <= '0;
            rx_r    <= '0;
            dout_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            cs_n_r  <= 1'b1;
            sclk_r  <= 1'b0;
            mosi_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        frame_r <= {bus.din, bus.addr, bus.wr};
                        wr_r    <= bus.wr;
                        busy_r  <= 1'b1;
                        state_r <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (addr_ok_s) begin
                        cs_n_r  <= 1'b0;
                        mosi_r  <= frame_r[0];
                        frame_r <= frame_r >> 1;
                        ph_r    <= '0;
                        cnt_r   <= '0;
                        state_r <= S_SEND;
                    end else begin
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_ERROR;
                    end
                end
                S_SEND: begin
                    if (ph_r == PH_LAST) begin
                        ph_r   <= '0;
                        sclk_r <= 1'b0;
                        if (send_last_s) begin
                            cs_n_r  <= 1'b1;
                            mosi_r  <= 1'b0;
                            cnt_r   <= '0;
                            state_r <= wr_r ? S_WAIT_OP : S_WAIT_RDY;
                        end else begin
                            cnt_r   <= cnt_inc_s;
                            mosi_r  <= frame_r[0];
                            frame_r <= frame_r >> 1;
                        end
                    end else begin
                        ph_r   <= ph_r + PH_W'(1);
                        sclk_r <= (ph_r >= PH_RISE);
                    end
                end
                S_WAIT_OP, S_WAIT_RDY: begin
                    // A handshake in the expiring cycle still wins over the timeout.
                    if (hs_s) begin
                        if (state_r == S_WAIT_OP) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= S_DONE;
                        end else begin
                            cs_n_r  <= 1'b0;
                            ph_r    <= '0;
                            cnt_r   <= '0;
                            state_r <= S_RECV;
                        end
                    end else if (cnt_inc_s == TMO) begin
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_ERROR;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                S_RECV: begin
                    if (ph_r == PH_RISE) begin
                        rx_r <= {miso, rx_r[DATA_W-1:1]};
                    end
                    if (ph_r == PH_LAST) begin
                        ph_r   <= '0;
                        sclk_r <= 1'b0;
                        if (cnt_r == LAST_RX) begin
                            cs_n_r  <= 1'b1;
                            dout_r  <= rx_r;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= S_DONE;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end else begin
                        ph_r   <= ph_r + PH_W'(1);
                        sclk_r <= (ph_r >= PH_RISE);
                    end
                end
                S_DONE, S_ERROR: begin
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    cs_n_r  <= 1'b1;
                    sclk_r  <= 1'b0;
                    mosi_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Parametrised SPI master that executes single register write/read transactions to an SPI slave memory. It serialises {data, addr, wr} LSB-first on mosi with a generated sclk and validates the address against the slave depth. Reads wait for the slave's ready handshake, then shift data in from miso. Slave handshakes are guarded by a timeout that raises err. It sits between a bus-side requester and the spi_mem slave model or device.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, address field width in bits
MEM_DEPTH, 32, number of valid slave addresses; addr >= MEM_DEPTH is an error
CLK_DIV, 2, clk cycles per sclk half-period (>=1)
TIMEOUT, 64, max clk cycles to wait for op_done/ready (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  transaction request; sampled only in IDLE
wr  input  1  1 = write, 0 = read; captured with start
addr  input  ADDR_W  target address; captured with start
din  input  DATA_W  write data; captured with start
dout  output  DATA_W  last successfully read data
busy  output  1  high from the cycle after start acceptance until return to IDLE
done  output  1  one-cycle pulse at the end of every transaction
err  output  1  one-cycle pulse with done on failure
cs_n  output  1  slave select, active low
sclk  output  1  serial clock, idles low (mode 0)
mosi  output  1  serial data to slave
miso  input  1  serial data from slave
ready  input  1  slave read data available
op_done  input  1  slave write complete

Behaviour:
- Reset (async, any state): IDLE; cs_n=1, sclk=0, mosi=0, done=0, err=0, busy=0, dout=0, counters=0.
- IDLE: if start, capture frame = {din, addr, wr} and go to CHECK. start in any other state is ignored.
- CHECK (1 cycle): addr < MEM_DEPTH -> SEND with cs_n=0. Otherwise -> ERROR with cs_n held at 1 and no sclk activity.
- SEND: N bits, LSB (wr) first. N = 1+ADDR_W+DATA_W for a write and 1+ADDR_W for a read.
  - Each bit lasts 2*CLK_DIV cycles.
  - mosi changes only while sclk is low, at the bit start.
  - sclk is low for the first CLK_DIV cycles of each bit and high for the next CLK_DIV cycles.
  - After the last bit: cs_n=1, mosi=0, sclk=0. A write goes to WAIT_OP; a read goes to WAIT_RDY. The timeout counter is cleared.
- WAIT_OP: op_done=1 -> DONE. Otherwise the counter increments. When the counter reaches TIMEOUT -> ERROR.
- WAIT_RDY: same as WAIT_OP with ready in place of op_done; ready=1 -> RECV with cs_n=0.
- Handshake priority: op_done/ready sampled high in the same cycle the timeout expires counts as success. Both are ignored outside their wait states.
- RECV: DATA_W sclk pulses with the same timing as SEND and mosi=0.
  - miso is sampled on each sclk rising edge into a shift register, LSB first.
  - After the last bit: cs_n=1, dout is loaded from the shift register -> DONE.
- DONE: done=1 for one cycle -> IDLE. busy falls in the same cycle done is high.
- ERROR: done=1 and err=1 for one cycle -> IDLE. dout is unchanged.
- dout changes only on a successful read. Failed reads and writes never alter it.
- Counters are sized for max(N, DATA_W, TIMEOUT) with no wrap-around. The bit counter resets to 0 on entry to SEND and RECV.
- A new start is accepted in the IDLE cycle after DONE/ERROR, so the minimum start-to-start interval equals the transaction length + 1.

Test Plan:
- Write addr=5, din=0xA5 (defaults), op_done pulsed 3 cycles after cs_n rises -> mosi stream is 1,0x05 LSB-first,0xA5 LSB-first; 17 sclk pulses; 68 clk with cs_n low; done=1, err=0; dout unchanged.
- Read addr=31 with the slave driving 0x3C, ready=1 2 cycles after the address phase -> 9 sclk pulses out, then 8 in; dout=0x3C; done=1, err=0.
- Write addr=32 -> no cs_n/sclk activity; done=1 and err=1 in the same cycle, 2 cycles after start; busy low the next cycle.
- Read addr=4 with ready never asserted -> err=1 and done=1 exactly 64 cycles after entering WAIT_RDY; dout keeps its prior value; cs_n=1.
- ready asserted on the same cycle the timeout reaches 64 -> read completes normally, err=0.
- rst asserted mid-SEND (bit 7) and start pulsed during busy -> outputs return to their reset values asynchronously, the pulse is ignored, and the next start after reset performs a full correct transaction.
